idivs_seq: RTL and testbench

- Signed/unsigned division sequencer for the CPU's divide ops: UM/MOD, SM/REM and FM/MOD.
- Sits upstream and downstream of the iterative unsigned divider (udiv).
- Upstream role: converts the signed operands to magnitudes and launches udiv.
- Downstream role: consumes udiv's quotient, remainder and overflow, then applies sign/floor correction and signed-range overflow detection.
- udiv is instantiated by the parent; this block only drives and reads its ports.

---
 rtl/idivs_seq_pkg.sv | 24 ++
 rtl/udiv.sv | 69 ++++++
 rtl/idivs_seq.sv | 149 ++++++++++++++
 tb/tb_idivs_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idivs_seq_pkg.sv
// Shared encodings and helpers for the signed division sequencer.
// Mode codes, FSM states and the conditional negate used on operands/results.
package idivs_seq_pkg;

  localparam logic [1:0] MODE_UMMOD = 2'b00;
  localparam logic [1:0] MODE_SMREM = 2'b01;
  localparam logic [1:0] MODE_FMMOD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    FIX    = 2'd3
  } state_e;

  // Two's-complement negate when neg is set; callers cast to their width.
  function automatic logic [63:0] abs_w(
    input logic        neg,
    input logic [63:0] v
  );
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/udiv.sv
// Iterative restoring unsigned divider, 2W / W, one quotient bit per cycle.
// Flags overflow up front (high half >= divisor) without ever going busy.
module udiv #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               go,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem,
  output logic               overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             busy_q;
  logic             ovf_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // Shift one dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    trial = {r_q, q_q[WIDTH-1]};
    fits  = trial >= {1'b0, d_q};
    diff  = trial[WIDTH-1:0] - d_q;
  end

  // Pre-check on go, then WIDTH restoring steps.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      r_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
    end else if (busy_q) begin
      r_q   <= fits ? diff : trial[WIDTH-1:0];
      q_q   <= {q_q[WIDTH-2:0], fits};
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end else if (go) begin
      if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
        ovf_q <= 1'b1;
      end else begin
        ovf_q  <= 1'b0;
        r_q    <= dividend[2*WIDTH-1:WIDTH];
        q_q    <= dividend[WIDTH-1:0];
        d_q    <= divisor;
        cnt_q  <= CW'(WIDTH);
        busy_q <= 1'b1;
      end
    end
  end

  assign busy     = busy_q;
  assign quot     = q_q;
  assign rem      = r_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/idivs_seq.sv
// Signed/unsigned division sequencer around an external unsigned divider.
// Feeds magnitudes to udiv, then applies sign, floor and range correction.
module idivs_seq
  import idivs_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               go,
  input  logic [1:0]         mode,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem,
  output logic               overflow,
  output logic               udiv_go,
  output logic [2*WIDTH-1:0] udiv_dividend,
  output logic [WIDTH-1:0]   udiv_divisor,
  input  logic               udiv_busy,
  input  logic [WIDTH-1:0]   udiv_quot,
  input  logic [WIDTH-1:0]   udiv_rem,
  input  logic               udiv_overflow
);

  localparam logic [WIDTH:0] HALF    = {2'b01, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0] HALF_M1 = HALF - (WIDTH+1)'(1);

  state_e             state_q, state_d;
  logic [1:0]         mode_q;
  logic               sd_q, sv_q;
  logic [WIDTH-1:0]   div_q;
  logic [2*WIDTH-1:0] udvd_q;
  logic [WIDTH-1:0]   udvs_q;
  logic [WIDTH-1:0]   quot_q, rem_q;
  logic               ovf_q, done_q;

  logic               accept, sgn_in, sd_in, sv_in;
  logic [1:0]         mode_in;
  logic               ns, is_sm, is_fm, fm_adj;
  logic [WIDTH-1:0]   qs, rs;
  logic [WIDTH:0]     q_ext, q_inc;
  logic [WIDTH-1:0]   fix_quot, fix_rem;
  logic               fix_ovf;

  // Request decode: go counts only in IDLE and not in the done cycle.
  always_comb begin
    accept  = (state_q == IDLE) & go & ~done_q;
    sgn_in  = (mode == MODE_SMREM) | (mode == MODE_FMMOD);
    sd_in   = sgn_in & dividend[2*WIDTH-1];
    sv_in   = sgn_in & divisor[WIDTH-1];
    mode_in = sgn_in ? mode : MODE_UMMOD;
  end

  // Next-state logic for the launch/wait/fix sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (!udiv_busy) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sign, floor and signed-range correction of the udiv result.
  always_comb begin
    ns       = sd_q ^ sv_q;
    is_sm    = mode_q == MODE_SMREM;
    is_fm    = mode_q == MODE_FMMOD;
    fm_adj   = is_fm & ns & (|udiv_rem);
    qs       = WIDTH'(abs_w(ns, 64'(udiv_quot)));
    rs       = WIDTH'(abs_w(sd_q, 64'(udiv_rem)));
    q_ext    = {1'b0, udiv_quot};
    q_inc    = q_ext + (WIDTH+1)'(1);
    fix_quot = udiv_quot;
    fix_rem  = udiv_rem;
    fix_ovf  = udiv_overflow;
    unique case (1'b1)
      fm_adj: begin
        fix_quot = qs - WIDTH'(1);
        fix_rem  = rs + div_q;
        fix_ovf  = udiv_overflow | (q_inc > HALF);
      end
      (is_sm | is_fm) & ~fm_adj: begin
        fix_quot = qs;
        fix_rem  = rs;
        fix_ovf  = udiv_overflow |
                   (ns ? (q_ext > HALF) : (q_ext > HALF_M1));
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Operand capture on an accepted go; held through LAUNCH and WAIT.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mode_q <= MODE_UMMOD;
      sd_q   <= 1'b0;
      sv_q   <= 1'b0;
      div_q  <= '0;
      udvd_q <= '0;
      udvs_q <= '0;
    end else if (accept) begin
      mode_q <= mode_in;
      sd_q   <= sd_in;
      sv_q   <= sv_in;
      div_q  <= divisor;
      udvd_q <= (2*WIDTH)'(abs_w(sd_in, 64'(dividend)));
      udvs_q <= WIDTH'(abs_w(sv_in, 64'(divisor)));
    end
  end

  // Result registers and the done pulse, written only in FIX.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      quot_q <= '0;
      rem_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= state_q == FIX;
      if (state_q == FIX) begin
        quot_q <= fix_ovf ? '1 : fix_quot;
        rem_q  <= fix_ovf ? '1 : fix_rem;
        ovf_q  <= fix_ovf;
      end
    end
  end

  assign busy          = state_q != IDLE;
  assign done          = done_q;
  assign quot          = quot_q;
  assign rem           = rem_q;
  assign overflow      = ovf_q;
  assign udiv_go       = state_q == LAUNCH;
  assign udiv_dividend = udvd_q;
  assign udiv_divisor  = udvs_q;

endmodule

// File: tb/tb_idivs_seq.sv
// Bench for idivs_seq with a udiv sibling, WIDTH=8.
// Expected results come from an integer reference and a scoreboard queue.
module tb_idivs_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           arst, go;
  logic [1:0]     mode;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy, done, overflow;
  logic [W-1:0]   quot, rem;
  logic           udiv_go, udiv_busy, udiv_overflow;
  logic [2*W-1:0] udiv_dividend;
  logic [W-1:0]   udiv_divisor, udiv_quot, udiv_rem;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  idivs_seq #(.WIDTH(W)) dut (
    .clk(clk), .arst(arst), .go(go), .mode(mode),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quot(quot), .rem(rem),
    .overflow(overflow), .udiv_go(udiv_go),
    .udiv_dividend(udiv_dividend), .udiv_divisor(udiv_divisor),
    .udiv_busy(udiv_busy), .udiv_quot(udiv_quot),
    .udiv_rem(udiv_rem), .udiv_overflow(udiv_overflow)
  );

  udiv #(.WIDTH(W)) u_div (
    .clk(clk), .arst(arst), .go(udiv_go),
    .dividend(udiv_dividend), .divisor(udiv_divisor),
    .busy(udiv_busy), .quot(udiv_quot), .rem(udiv_rem),
    .overflow(udiv_overflow)
  );

  function automatic exp_t model(input logic [1:0] m,
                                 input logic [15:0] a,
                                 input logic [7:0] b);
    exp_t   e;
    longint sa, sbv, tq, tr;
    e.q = 8'hFF; e.r = 8'hFF; e.ovf = 1'b1;
    if (m == 2'b01 || m == 2'b10) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      if (sbv != 0) begin
        tq = sa / sbv;
        tr = sa % sbv;
        if (m == 2'b10 && tr != 0 && ((tr < 0) != (sbv < 0))) begin
          tq = tq - 1;
          tr = tr + sbv;
        end
        if (tq >= -128 && tq <= 127) begin
          e.q = tq[7:0]; e.r = tr[7:0]; e.ovf = 1'b0;
        end
      end
    end else begin
      sa  = longint'(a);
      sbv = longint'(b);
      if (sbv != 0 && sa / sbv <= 255) begin
        tq = sa / sbv;
        tr = sa % sbv;
        e.q = tq[7:0]; e.r = tr[7:0]; e.ovf = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic launch(input logic [1:0] m, input logic [15:0] a,
                        input logic [7:0] b);
    @(negedge clk);
    mode = m; dividend = a; divisor = b; go = 1'b1;
    sb.push_back(model(m, a, b));
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    arst = 1'b1; go = 1'b0; mode = 2'b00;
    dividend = '0; divisor = '0;
    @(negedge clk);
    n_chk++;
    if ({busy, done, quot, rem, overflow, udiv_go,
         udiv_dividend, udiv_divisor} !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b q=%h r=%h ovf=%b ugo=%b required all 0",
               busy, done, quot, rem, overflow, udiv_go);
    end
    arst = 1'b0;
  endtask

  task automatic test_ummod;
    int lat; exp_t e;
    launch(2'b00, 16'h1234, 8'h56);
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL um_busy: got %b required 1", busy);
    end
    wait_done(lat);
    e = sb.pop_front();
    n_chk++;
    if (lat !== 11) begin
      n_fail++; $display("FAIL um_latency: got %0d required 11", lat);
    end
    n_chk++;
    if ({quot, rem, overflow} !== {e.q, e.r, e.ovf}) begin
      n_fail++;
      $display("FAIL um_result: got %h/%h/%b required %h/%h/%b",
               quot, rem, overflow, e.q, e.r, e.ovf);
    end
    n_chk++;
    if ({quot, rem, overflow} !== {8'h36, 8'h10, 1'b0}) begin
      n_fail++;
      $display("FAIL um_const: got %h/%h/%b required 36/10/0",
               quot, rem, overflow);
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || quot !== 8'h36) begin
      n_fail++;
      $display("FAIL um_pulse_hold: done=%b q=%h required 0/36", done, quot);
    end
  endtask

  task automatic test_smrem;
    int lat; exp_t e;
    logic [15:0] av [3] = '{16'hFFF9, 16'h0080, 16'hFF80};
    logic [7:0]  bv [3] = '{8'h02, 8'h01, 8'h01};
    for (int i = 0; i < 3; i++) begin
      launch(2'b01, av[i], bv[i]);
      wait_done(lat);
      e = sb.pop_front();
      n_chk++;
      if (!done || {quot, rem, overflow} !== {e.q, e.r, e.ovf}) begin
        n_fail++;
        $display("FAIL sm_%0d: done=%b got %h/%h/%b required %h/%h/%b",
                 i, done, quot, rem, overflow, e.q, e.r, e.ovf);
      end
      if (i == 0) begin
        n_chk++;
        if ({udiv_dividend, udiv_divisor} !== {16'h0007, 8'h02}) begin
          n_fail++;
          $display("FAIL sm_mag: got %h/%h required 0007/02",
                   udiv_dividend, udiv_divisor);
        end
      end
    end
  endtask

  task automatic test_fmmod;
    int lat; exp_t e;
    logic [15:0] av [2] = '{16'hFFF9, 16'h0007};
    logic [7:0]  bv [2] = '{8'h02, 8'hFE};
    logic [15:0] rq [2] = '{16'hFC01, 16'hFCFF};
    for (int i = 0; i < 2; i++) begin
      launch(2'b10, av[i], bv[i]);
      wait_done(lat);
      e = sb.pop_front();
      n_chk++;
      if (!done || {quot, rem, overflow} !== {e.q, e.r, e.ovf}) begin
        n_fail++;
        $display("FAIL fm_%0d: done=%b got %h/%h/%b required %h/%h/%b",
                 i, done, quot, rem, overflow, e.q, e.r, e.ovf);
      end
      n_chk++;
      if ({quot, rem} !== rq[i]) begin
        n_fail++;
        $display("FAIL fm_const_%0d: got %h%h required %h",
                 i, quot, rem, rq[i]);
      end
    end
  endtask

  task automatic test_divzero;
    int lat, extra; exp_t e;
    for (int m = 0; m < 4; m++) begin
      launch(2'(m), 16'h1234 ^ 16'(m << 12), 8'h00);
      n_chk++;
      if (busy !== 1'b1) begin
        n_fail++; $display("FAIL dz_busy_%0d: got %b required 1", m, busy);
      end
      mode = 2'b00; dividend = 16'h0010; divisor = 8'h03; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      wait_done(lat);
      e = sb.pop_front();
      n_chk++;
      if (lat + 1 !== 3 || {quot, rem, overflow} !== {e.q, e.r, e.ovf}) begin
        n_fail++;
        $display("FAIL dz_%0d: lat=%0d got %h/%h/%b required 3 %h/%h/%b",
                 m, lat + 1, quot, rem, overflow, e.q, e.r, e.ovf);
      end
      mode = 2'b00; dividend = 16'h0010; divisor = 8'h03; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      n_chk++;
      if (busy !== 1'b0) begin
        n_fail++; $display("FAIL dz_go_at_done_%0d: busy=%b required 0", m, busy);
      end
      extra = 0;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk);
        if (done) extra++;
      end
      n_chk++;
      if (extra !== 0) begin
        n_fail++; $display("FAIL dz_ignored_%0d: extra dones %0d required 0", m, extra);
      end
    end
  endtask

  task automatic test_reset_mid;
    int lat; exp_t e;
    launch(2'b00, 16'h1234, 8'h56);
    repeat (4) @(negedge clk);
    arst = 1'b1;
    #1;
    void'(sb.pop_back());
    n_chk++;
    if ({busy, done, quot, rem, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b q=%h r=%h ovf=%b required 0",
               busy, done, quot, rem, overflow);
    end
    @(negedge clk);
    arst = 1'b0;
    launch(2'b01, 16'hFFF9, 8'h02);
    wait_done(lat);
    e = sb.pop_front();
    n_chk++;
    if (!done || {quot, rem, overflow} !== {e.q, e.r, e.ovf}) begin
      n_fail++;
      $display("FAIL after_reset: done=%b got %h/%h/%b required %h/%h/%b",
               done, quot, rem, overflow, e.q, e.r, e.ovf);
    end
  endtask

  task automatic test_back_to_back;
    int lat; exp_t e;
    logic [15:0] a; logic [7:0] b; logic [1:0] m;
    for (int i = 0; i < 24; i++) begin
      m = 2'($urandom_range(0, 3));
      a = 16'($urandom);
      if (i[0]) a = {{8{a[7]}}, a[7:0]};
      b = 8'($urandom);
      launch(m, a, b);
      wait_done(lat);
      e = sb.pop_front();
      n_chk++;
      if (!done || {quot, rem, overflow} !== {e.q, e.r, e.ovf}) begin
        n_fail++;
        $display("FAIL b2b_%0d m=%0d %h/%h: done=%b got %h/%h/%b required %h/%h/%b",
                 i, m, a, b, done, quot, rem, overflow, e.q, e.r, e.ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ummod();
    test_smrem();
    test_fmmod();
    test_divzero();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
